// File: rtl/mips_pkg.sv
// mips_pkg: opcode, ALUOp, mux-select and state encodings shared by the multicycle MIPS control path.
package mips_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_e;
  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  endfunction
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: controller <-> datapath bundle; master is the controller, slave the datapath.
interface mips_multicycle_control_if;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_en_o;
  logic [1:0] pc_source_o;
  logic       ior_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       mem_to_reg_o;
  logic       reg_dst_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] alu_op_o;
  logic       instr_done_o;
  logic       illegal_op_o;
  logic [3:0] state_o;
  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_en_o, pc_source_o, ior_d_o, mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o,
           reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o,
           illegal_op_o, state_o
  );
  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_en_o, pc_source_o, ior_d_o, mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o,
           reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o,
           illegal_op_o, state_o
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM; outputs decoded from state, stalling on MemReady.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mips_multicycle_control_if.master bus
);
  state_e state_q, state_d;
  logic [5:0] op;
  logic rdy;
  logic pc_en, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
  logic alu_src_a, instr_done, illegal;
  logic [1:0] pc_source, alu_src_b, alu_op;
  assign op  = bus.opcode_i;
  assign rdy = bus.mem_ready_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: state_d = (op == OP_LW || op == OP_SW)   ? S_MEMADR :
                          op == OP_R                       ? S_EXEC   :
                          (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
                          op == OP_ADDI                    ? S_ADDIEX :
                          op == OP_J                       ? S_JUMP   : S_FETCH;
      S_MEMADR: state_d = op == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
  always_comb begin
    pc_en      = 1'b0;
    pc_source  = PCSRC_ALU;
    ior_d      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_RTYPE;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH:  begin mem_read = 1'b1; alu_src_b = SRCB_FOUR; alu_op = ALUOP_ADD; ir_write = rdy; pc_en = rdy; end
      S_DECODE: begin alu_src_b = SRCB_IMM_SH; alu_op = ALUOP_ADD; illegal = !op_legal(op); instr_done = !op_legal(op); end
      S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALUOP_ADD; end
      S_MEMRD:  begin mem_read = 1'b1; ior_d = 1'b1; end
      S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
      S_MEMWR:  begin mem_write = 1'b1; ior_d = 1'b1; instr_done = rdy; end
      S_EXEC:   begin alu_src_a = 1'b1; alu_op = ALUOP_RTYPE; end
      S_ALUWB:  begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_source  = PCSRC_ALUOUT;
        instr_done = 1'b1;
        pc_en      = op == OP_BNE ? !bus.zero_i : bus.zero_i;
      end
      S_ADDIEX: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; alu_op = ALUOP_ADD; end
      S_ADDIWB: begin reg_write = 1'b1; instr_done = 1'b1; end
      S_JUMP:   begin pc_source = PCSRC_JUMP; pc_en = 1'b1; instr_done = 1'b1; end
      default: ;
    endcase
  end
  // Reset must block every architectural write; the selects keep showing FETCH decode.
  assign bus.pc_en_o      = rst_n & pc_en;
  assign bus.ir_write_o   = rst_n & ir_write;
  assign bus.reg_write_o  = rst_n & reg_write;
  assign bus.mem_write_o  = rst_n & mem_write;
  assign bus.instr_done_o = rst_n & instr_done;
  assign bus.illegal_op_o = rst_n & illegal;
  assign bus.pc_source_o  = pc_source;
  assign bus.ior_d_o      = ior_d;
  assign bus.mem_read_o   = mem_read;
  assign bus.mem_to_reg_o = mem_to_reg;
  assign bus.reg_dst_o    = reg_dst;
  assign bus.alu_src_a_o  = alu_src_a;
  assign bus.alu_src_b_o  = alu_src_b;
  assign bus.alu_op_o     = alu_op;
  assign bus.state_o      = state_q;
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control state machine for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register, steps each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable and mux select. It also produces the 2-bit `ALUOp` consumed by `alucontrol`. Memory accesses use a ready handshake, so the FSM stalls in memory states until the access completes.

## Interface

No parameters. Encodings are fixed by the package constants listed under Structure.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `Opcode` in 6: instruction `[31:26]` from IR; stable from DECODE through instruction end.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current read/write this cycle.
- `PCEn` out 1: PC load enable (unconditional and conditional writes combined).
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `IorD` out 1: 0 PC addresses memory, 1 ALUOut addresses memory.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `IRWrite` out 1: load IR from memory data.
- `MemtoReg` out 1: register write data (0 ALUOut, 1 MDR).
- `RegDst` out 1: write register (0 rt, 1 rd).
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A input (0 PC, 1 A register).
- `ALUSrcB` out 2: ALU B input (00 B, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate << 2).
- `ALUOp` out 2: 00 R-format (funct decides), 01 branch (subtract), 10 add.
- `InstrDone` out 1: one-cycle pulse in the final cycle of each instruction.
- `IllegalOp` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `State` out 4: current state, for debug.

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation

- Supported opcodes:
  - R 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - bne 000101
  - addi 001000
  - j 000010
- Moore FSM, 4-bit state register, with these encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
  - Codes 12–15 go to FETCH on the next edge; all outputs are 0 while in them.
- Outputs are decoded combinationally from state. `PCEn`, `IRWrite` and `InstrDone` may also depend on `Zero`, `MemReady` and `Opcode`. Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - **FETCH:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=10, PCSource=00. IRWrite=PCEn=MemReady. Go to DECODE when MemReady, else hold.
  - **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=10 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEMADR
    - R → EXEC
    - beq/bne → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - other → FETCH, with IllegalOp=1 and InstrDone=1
  - **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=10. Go to MEMRD for lw, MEMWR for sw.
  - **MEMRD:** MemRead=1, IorD=1. Go to MEMWB when MemReady.
  - **MEMWB:** RegWrite=1, RegDst=0, MemtoReg=1, InstrDone=1. Go to FETCH.
  - **MEMWR:** MemWrite=1, IorD=1. When MemReady: InstrDone=1, go to FETCH.
  - **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=00. Go to ALUWB.
  - **ALUWB:** RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. Go to FETCH.
  - **BRANCH:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, InstrDone=1. PCEn=Zero for beq, ~Zero for bne. Go to FETCH.
  - **ADDIEX:** ALUSrcA=1, ALUSrcB=10, ALUOp=10. Go to ADDIWB.
  - **ADDIWB:** RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1. Go to FETCH.
  - **JUMP:** PCSource=10, PCEn=1, InstrDone=1. Go to FETCH.
- MemRead/MemWrite stay asserted, with IorD stable, for every stall cycle until MemReady.
- MemReady is ignored in all states other than FETCH, MEMRD and MEMWR.

## Timing

- Reset:
  - While `rst_n`=0, the state is FETCH.
  - PCEn, IRWrite, RegWrite, MemWrite, InstrDone and IllegalOp are forced to 0. The remaining outputs show FETCH decode.
  - The first fetch is performed after `rst_n` rises.
- Reset asserted mid-instruction: immediate return to FETCH. No partial write may occur after the assertion.
- Cycle counts with zero-wait memory (MemReady=1 at the first request):
  - R 4, lw 5, sw 4, addi 4, beq/bne 3, j 3, illegal 2.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- PCEn is a single-cycle pulse per PC update. FETCH and BRANCH never assert PCEn in the same cycle.

## Structure

- Shared package `mips_pkg` holds:
  - opcode constants
  - `ALUOp` constants (00/01/10), shared with `alucontrol`
  - the state enum/encoding
  - `ALUSrcB` and `PCSource` select constants
- No sub-module. A single FSM module with a next-state block and an output-decode block.

## Test plan

- **Reset:** reset mid-lw in MEMRD, release → State=0. MemWrite and RegWrite stay 0 throughout.
- **R-format back to back:** Opcode=000000, MemReady held 1.
  - Sequence 0,1,6,7,0; ALUOp=00 in EXEC; RegDst=1 and RegWrite=1 in ALUWB.
  - InstrDone pulses every 4 cycles.
- **lw with stalls:** MemReady low 2 cycles in FETCH and 3 cycles in MEMRD.
  - 10 cycles total; IRWrite pulses exactly once; MemtoReg=1 with RegWrite in MEMWB.
- **sw:**
  - MEMWR holds MemWrite=1 and IorD=1 until MemReady.
  - RegWrite is never 1 during the instruction.
- **Branches:**
  - beq with Zero=1 → PCEn=1, PCSource=01 in BRANCH.
  - bne with Zero=1 → PCEn=0.
  - ALUOp=01 in both cases.
- **Jump and illegal opcodes:**
  - j → PCEn=1 with PCSource=10 in cycle 3.
  - Opcode=111111 → IllegalOp and InstrDone pulse in DECODE; back to FETCH next cycle.
